// File: rtl/serial_sub_pkg.sv
`default_nettype none
// serial_sub_pkg: shared state encoding and default width for the serial subtractor.
// Revision 1.0
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// full_subtractor: one-bit a - b - bin built from gate primitives.
// Revision 1.0
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire axb;
  wire na;
  wire nxb;
  wire gen;
  wire prop;

  xor g_x1 (axb, a, b);
  xor g_x2 (d, axb, bin);
  not g_n1 (na, a);
  and g_a1 (gen, na, b);
  // When the bits are equal the incoming borrow passes straight through.
  not g_n2 (nxb, axb);
  and g_a2 (prop, nxb, bin);
  or  g_o1 (bout, gen, prop);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// serial_subtractor: bit-serial unsigned a - b, LSB first, one full-subtractor cell.
// Revision 1.0
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  sub_state_t       state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] cnt;
  logic             bw;
  logic             cell_d;
  logic             cell_bout;
  logic             last;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last = (cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      bw     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            bw   <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= {cell_d, r_sh[WIDTH-1:1]};
          bw   <= cell_bout;
          // The final bit goes straight to diff so the result is visible with done.
          if (last) begin
            diff   <= {cell_d, r_sh[WIDTH-1:1]};
            borrow <= cell_bout;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// tb_serial_subtractor: table-driven and randomized checks against an arithmetic model.
// Revision 1.0
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer subtraction reduced modulo 256.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
    int d;
    d = int'(x) - int'(y);
    return {(d < 0), 8'((d + 256) % 256)};
  endfunction

  // Issue one operation and verify busy length, done pulse and result.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [7:0] ed, input logic eb, input bit mid_pulse,
                       input string nm);
    int cyc;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    @(negedge clk);
    start = 1'b0; a = 8'hxx; b = 8'hxx;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      if (mid_pulse && cyc == 3) begin
        start = 1'b1; a = 8'd1; b = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, " busy_cycles"}, cyc, 8);
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " diff"}, diff, ed);
    chk({nm, " borrow"}, borrow, eb);
    @(negedge clk);
    chk({nm, " done_low"}, done, 1'b0);
  endtask

  initial begin
    vec_t       vecs[5];
    logic [8:0] m;
    int         d0;
    int         acc_t[$];
    int         cyc;
    logic       prev_busy;

    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'hFC,  1'b1};
    vecs[2] = '{8'hA5,  8'hA5,  8'h00,  1'b0};
    vecs[3] = '{8'h00,  8'hFF,  8'h01,  1'b1};
    vecs[4] = '{8'hFF,  8'h00,  8'hFF,  1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, 8'h00);
    chk("reset borrow", borrow, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, 1'b0, $sformatf("vec%0d", i));

    // start pulsed while running must not launch a second operation
    d0 = done_cnt;
    do_op(8'd20, 8'd3, 8'd17, 1'b0, 1'b1, "ignored_start");
    repeat (12) @(negedge clk);
    chk("ignored_start done_count", done_cnt - d0, 1);

    // start held high: accepts every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'd50; b = 8'd8;
    prev_busy = busy;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) acc_t.push_back(cyc);
      prev_busy = busy;
    end
    start = 1'b0;
    chk("held_start accepts", acc_t.size(), 4);
    for (int i = 1; i < acc_t.size(); i++)
      chk($sformatf("held_start interval%0d", i), acc_t[i] - acc_t[i-1], 10);
    repeat (12) @(negedge clk);
    chk("held_start diff", diff, 8'd42);

    // leave a nonzero result with borrow so the async reset visibly clears it
    do_op(8'd5, 8'd9, 8'hFC, 1'b1, 1'b0, "pre_reset");
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_reset busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset busy", busy, 1'b0);
    chk("mid_reset done", done, 1'b0);
    chk("mid_reset diff", diff, 8'h00);
    chk("mid_reset borrow", borrow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_reset no_done", done_cnt - d0, 0);
    chk("mid_reset idle", busy, 1'b0);
    do_op(8'd9, 8'd4, 8'd5, 1'b0, 1'b0, "post_reset");

    d0 = done_cnt;
    for (int i = 0; i < 500; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 50 == 0) rb = ra;
      m = model(ra, rb);
      do_op(ra, rb, m[7:0], m[8], 1'b0, $sformatf("rand%0d", i));
    end
    chk("random done_count", done_cnt - d0, 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` LSB-first, one bit per clock, using a single gate-level full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's gate-level adder cells: the same one-bit arithmetic primitive style, wrapped in a start/busy/done sequencer. It trades WIDTH cycles of latency for a single arithmetic cell, and is intended for area-constrained datapaths.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are ≥ 2.
- One clock; reset is asynchronous and active-low.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous active-low reset.
- `start` input, 1: request a subtraction; sampled only in IDLE.
- `a` input, WIDTH: minuend; captured on the edge that accepts `start`.
- `b` input, WIDTH: subtrahend; captured on the same edge as `a`.
- `busy` output, 1: high while bits are being processed (RUN state).
- `done` output, 1: one-cycle pulse when `diff` and `borrow` update.
- `diff` output, WIDTH: `(a - b) mod 2^WIDTH`; holds its value until the next completion.
- `borrow` output, 1: final borrow out, equal to 1 iff `a < b` (unsigned); holds like `diff`.

## Operation
- FSM states, with transitions evaluated on each rising edge:
  - IDLE: if `start`=1, load shift regs `A`←`a` and `B`←`b`, clear borrow flop `bw`←0, clear counter `cnt`←0, go to RUN.
  - RUN: each edge, `d = A[0]^B[0]^bw` and `bw ← (~A[0]&B[0]) | (~(A[0]^B[0])&bw)`. Shift `A` and `B` right by one. Shift the result reg `R` right, inserting `d` at the MSB. Increment `cnt`.
  - RUN exit: on the edge where `cnt == WIDTH-1`, the last bit is processed, `diff`←final `R` and `borrow`←final `bw`, and the FSM goes to DONE.
  - DONE: go to IDLE unconditionally on the next edge.
- `start` is ignored in RUN and DONE; `a` and `b` are don't-care outside the accept edge.
- Arithmetic is unsigned with modulo-2^WIDTH wrap. There is no signed interpretation and no overflow flag.
- `cnt` width is `$clog2(WIDTH)`; it never wraps within an operation.
- Reset (`rst_n`=0 at any time, including mid-RUN) immediately forces:
  - state IDLE;
  - `busy`=0, `done`=0, `diff`=0, `borrow`=0;
  - internal regs to 0.
  - The operation in flight is discarded, and no `done` pulse is produced for it.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0.
- Accept edge E0: `busy` rises after E0.
- Bits are processed on edges E1..E_WIDTH.
- After E_WIDTH: `busy`=0, `done`=1, and `diff`/`borrow` hold the new result, all in the same cycle.
- After E_WIDTH+1: `done`=0 and the FSM is in IDLE. The earliest next accept edge is E_WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `serial_sub_pkg` holds:
  - state typedef `sub_state_t` (2-bit enum): IDLE=0, RUN=1, DONE=2; encoding 3 is unused and recovers to IDLE.
  - a `DEFAULT_WIDTH` constant = 8.
- Sub-module `full_subtractor`:
  - ports `(a, b, bin, d, bout)`;
  - gate-level primitives only (xor/and/or/not);
  - instantiated exactly once for the RUN datapath.
- Top module contains the FSM, shift registers, counter, borrow flop and output registers.

## Test plan
All scenarios use WIDTH=8 and check against a behavioural `a-b` reference model.
- `a`=100, `b`=37, `start` pulsed → `busy` high for exactly 8 cycles, then `done` pulse with `diff`=8'd63, `borrow`=0.
- `a`=5, `b`=9 → `diff`=8'hFC, `borrow`=1.
- Boundary operands:
  - `a`=`b`=8'hA5 → `diff`=0, `borrow`=0.
  - `a`=0, `b`=8'hFF → `diff`=8'h01, `borrow`=1.
  - `a`=8'hFF, `b`=0 → `diff`=8'hFF, `borrow`=0.
- Ignored `start`:
  - Start `a`=20, `b`=3; during RUN pulse `start` with `a`=1, `b`=2 → single `done`, `diff`=17.
  - Hold `start`=1 continuously → accepts occur exactly every 10 cycles.
- Mid-operation reset:
  - Drive `rst_n` low during the 4th RUN cycle → `busy`, `done`, `diff`, `borrow` all 0 with no clock edge required.
  - After release, `a`=9, `b`=4 → `diff`=5.
- Random: 500 random `a`/`b` pairs → every `diff`/`borrow` matches the model, and `done` count equals accept count.
